// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare direction predictor with tagged direct-mapped BTB
// Combinational lookup for IF, resolved update from ID, saturating mispredict counter.
module branch_predictor_gshare #(
  parameter int DATA_W    = 64,
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6,
  parameter int CNT_W     = 2,
  parameter int BTB_IDX_W = 4,
  parameter int TAG_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [DATA_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       perf_mispredicts
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  // A zero-length history still needs a 1-bit register; it is simply never written.
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]  pht        [PHT_N];
  logic              btb_valid  [BTB_N];
  logic [TAG_W-1:0]  btb_tag    [BTB_N];
  logic [DATA_W-1:0] btb_target [BTB_N];
  logic              btb_jump   [BTB_N];
  logic [GW-1:0]     ghr;
  logic [31:0]       perf_cnt;

  logic [PHT_IDX_W-1:0] hist;
  logic [PHT_IDX_W-1:0] f_pidx, u_pidx;
  logic [BTB_IDX_W-1:0] f_bidx, u_bidx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic                 u_t;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc, upd_pc};

  always_comb begin
    hist = '0;
    if (GHR_W > 0) hist[GW-1:0] = ghr;
  end

  assign f_pidx = fetch_pc[2 +: PHT_IDX_W] ^ hist;
  assign f_bidx = fetch_pc[2 +: BTB_IDX_W];
  assign f_tag  = fetch_pc[2 + BTB_IDX_W +: TAG_W];
  assign u_pidx = upd_pc[2 +: PHT_IDX_W] ^ hist;
  assign u_bidx = upd_pc[2 +: BTB_IDX_W];
  assign u_tag  = upd_pc[2 + BTB_IDX_W +: TAG_W];
  assign u_t    = upd_is_jump | upd_taken;

  assign pred_hit    = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);
  assign pred_taken  = pred_hit && (btb_jump[f_bidx] || pht[f_pidx][CNT_W-1]);
  assign pred_target = pred_taken ? btb_target[f_bidx] : fetch_pc + DATA_W'(4);

  assign mispredict = upd_valid &&
                      ((u_t != upd_pred_taken) || (u_t && (upd_target != upd_pred_target)));
  assign perf_mispredicts = perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= CNT_WEAK;
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
      ghr      <= '0;
      perf_cnt <= '0;
    end else if (en) begin
      if (upd_valid) begin
        if (!upd_is_jump) begin
          if (u_t && pht[u_pidx] != CNT_MAX)
            pht[u_pidx] <= pht[u_pidx] + CNT_W'(1);
          else if (!u_t && pht[u_pidx] != '0)
            pht[u_pidx] <= pht[u_pidx] - CNT_W'(1);
          if (GHR_W > 0) ghr <= GW'({ghr, u_t});
        end
        // Taken outcomes claim the slot outright, evicting any aliasing entry.
        if (u_t) begin
          btb_valid[u_bidx]  <= 1'b1;
          btb_tag[u_bidx]    <= u_tag;
          btb_target[u_bidx] <= upd_target;
          btb_jump[u_bidx]   <= upd_is_jump;
        end
      end
      if (mispredict && perf_cnt != 32'hFFFF_FFFF)
        perf_cnt <= perf_cnt + 32'd1;
    end
  end

endmodule
